// File: rtl/video_pkg.sv
// Shared video timing for the 640x400 generator and capture.
// Holds visible/porch/sync sizes and the rgb pixel type.
package video_pkg;

    localparam int HZV = 640;
    localparam int HZF = 16;
    localparam int HZS = 96;
    localparam int HZB = 48;
    localparam int HZW = HZV + HZF + HZS + HZB;

    localparam int VTV = 400;
    localparam int VTF = 12;
    localparam int VTS = 2;
    localparam int VTB = 35;
    localparam int VTW = VTV + VTF + VTS + VTB;

    typedef logic [2:0] rgb_t;

endpackage

// File: rtl/video_capture_if.sv
// Sync/RGB video stream: hs, vs (active low), r, g, b.
// master = video source, slave = capture.
interface video_capture_if;

    logic hs;
    logic vs;
    logic r;
    logic g;
    logic b;

    modport master (output hs, vs, r, g, b);
    modport slave  (input  hs, vs, r, g, b);

endinterface

// File: rtl/video_sync_edge.sv
// Registers one sync input and flags its rising edge.
// Ports: clock, reset_n, sync_i, rise_o (combinational pulse).
module video_sync_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic sync_i,
    output logic rise_o
);

    logic sync_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) sync_q <= 1'b1;
        else          sync_q <= sync_i;
    end

    assign rise_o = sync_i & ~sync_q;

endmodule

// File: rtl/video_capture.sv
// VGA-style capture: recovers X/Y from hs/vs, measures timing,
// locks after good frames and emits one write per visible pixel.
// Ports: clock, reset_n, vid (stream slave), we/x/y/data (write),
// frame_done, locked, line_len, frame_lines (status).
module video_capture
    import video_pkg::*;
#(
    parameter int HZV         = video_pkg::HZV,
    parameter int HZB         = video_pkg::HZB,
    parameter int HZW         = video_pkg::HZW,
    parameter int VTV         = video_pkg::VTV,
    parameter int VTB         = video_pkg::VTB,
    parameter int VTW         = video_pkg::VTW,
    parameter int PIX_DELAY   = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    video_capture_if.slave vid,
    output logic          we,
    output logic [9:0]    x,
    output logic [8:0]    y,
    output rgb_t          data,
    output logic          frame_done,
    output logic          locked,
    output logic [11:0]   line_len,
    output logic [10:0]   frame_lines
);

    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    // pixel window in source-counter terms (rgb lags sync by PIX_DELAY)
    localparam logic [11:0] XLO = 12'(HZB + PIX_DELAY);
    localparam logic [11:0] XHI = 12'(HZB + HZV + PIX_DELAY);
    localparam logic [10:0] YLO = 11'(VTB);
    localparam logic [10:0] YHI = 11'(VTB + VTV);

    logic hrise, vrise;

    video_sync_edge u_hs (
        .clock  (clock),
        .reset_n(reset_n),
        .sync_i (vid.hs),
        .rise_o (hrise)
    );

    video_sync_edge u_vs (
        .clock  (clock),
        .reset_n(reset_n),
        .sync_i (vid.vs),
        .rise_o (vrise)
    );

    logic [11:0]   hc_q, hc_d;
    logic [10:0]   vc_q, vc_d;
    logic [GW-1:0] good_q, good_d;
    logic          have_line_q, have_line_d;
    logic          have_frame_q, have_frame_d;
    logic          line_bad_q, line_bad_d;
    logic          vs_pend_q, vs_pend_d;
    logic          locked_q, locked_d;
    logic          we_q, we_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    rgb_t          data_q, data_d;
    logic          fdone_q, fdone_d;
    logic [11:0]   llen_q, llen_d;
    logic [10:0]   flines_q, flines_d;

    logic [11:0] cur_x;
    logic [10:0] vc_nx;
    logic        boundary;
    logic        line_err;
    logic        frame_ok;
    logic        vis;

    always_comb begin
        hc_d         = (&hc_q) ? hc_q : hc_q + 12'd1;
        vc_d         = vc_q;
        good_d       = good_q;
        have_line_d  = have_line_q;
        have_frame_d = have_frame_q;
        line_bad_d   = line_bad_q;
        vs_pend_d    = vs_pend_q | vrise;
        locked_d     = locked_q;
        we_d         = 1'b0;
        x_d          = x_q;
        y_d          = y_q;
        data_d       = data_q;
        fdone_d      = 1'b0;
        llen_d       = llen_q;
        flines_d     = flines_q;

        cur_x    = hrise ? 12'd0 : hc_q;
        vc_nx    = (&vc_q) ? vc_q : vc_q + 11'd1;
        boundary = hrise & (vs_pend_q | vrise);
        line_err = hrise & have_line_q & (hc_q != 12'(HZW));
        // the line just ended belongs to the frame ending here
        frame_ok = have_frame_q & (vc_nx == 11'(VTW))
                 & ~line_bad_q & ~line_err;

        if (hrise) begin
            hc_d        = 12'd1;
            have_line_d = 1'b1;
            if (have_line_q) llen_d = hc_q;
            if (line_err) begin
                line_bad_d = 1'b1;
                locked_d   = 1'b0;
                good_d     = '0;
            end
            if (boundary) begin
                vc_d         = '0;
                vs_pend_d    = 1'b0;
                fdone_d      = 1'b1;
                have_frame_d = 1'b1;
                line_bad_d   = 1'b0;
                if (have_frame_q) begin
                    flines_d = vc_nx;
                    if (frame_ok) begin
                        if (int'(good_q) < LOCK_FRAMES)
                            good_d = good_q + GW'(1);
                        if (int'(good_q) + 1 >= LOCK_FRAMES)
                            locked_d = 1'b1;
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                    end
                end
            end else begin
                vc_d = vc_nx;
            end
        end

        vis = (cur_x >= XLO) && (cur_x < XHI)
           && (vc_q >= YLO) && (vc_q < YHI);

        // gated by next-state lock so a loss stops writes at once
        if (locked_d && vis) begin
            we_d   = 1'b1;
            x_d    = 10'(cur_x - XLO);
            y_d    = 9'(vc_q - YLO);
            data_d = {vid.r, vid.g, vid.b};
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hc_q         <= '0;
            vc_q         <= '0;
            good_q       <= '0;
            have_line_q  <= 1'b0;
            have_frame_q <= 1'b0;
            line_bad_q   <= 1'b0;
            vs_pend_q    <= 1'b0;
            locked_q     <= 1'b0;
            we_q         <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            data_q       <= '0;
            fdone_q      <= 1'b0;
            llen_q       <= '0;
            flines_q     <= '0;
        end else begin
            hc_q         <= hc_d;
            vc_q         <= vc_d;
            good_q       <= good_d;
            have_line_q  <= have_line_d;
            have_frame_q <= have_frame_d;
            line_bad_q   <= line_bad_d;
            vs_pend_q    <= vs_pend_d;
            locked_q     <= locked_d;
            we_q         <= we_d;
            x_q          <= x_d;
            y_q          <= y_d;
            data_q       <= data_d;
            fdone_q      <= fdone_d;
            llen_q       <= llen_d;
            flines_q     <= flines_d;
        end
    end

    assign we          = we_q;
    assign x           = x_q;
    assign y           = y_q;
    assign data        = data_q;
    assign frame_done  = fdone_q;
    assign locked      = locked_q;
    assign line_len    = llen_q;
    assign frame_lines = flines_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture on a reduced 16x6 raster
// (line 32 clocks, frame 13 lines) driven by a generator model.
module tb_video_capture;

    localparam int T_HZV = 16;
    localparam int T_HZB = 6;
    localparam int T_HZS = 6;
    localparam int T_HZW = 32;
    localparam int T_VTV = 6;
    localparam int T_VTB = 3;
    localparam int T_VTS = 2;
    localparam int T_VTW = 13;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b1;
    logic        we;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [2:0]  data;
    logic        frame_done;
    logic        locked;
    logic [11:0] line_len;
    logic [10:0] frame_lines;

    always #5 clock = ~clock;

    video_capture_if vid ();

    video_capture #(
        .HZV(T_HZV), .HZB(T_HZB), .HZW(T_HZW),
        .VTV(T_VTV), .VTB(T_VTB), .VTW(T_VTW),
        .PIX_DELAY(1), .LOCK_FRAMES(2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .vid        (vid),
        .we         (we),
        .x          (x),
        .y          (y),
        .data       (data),
        .frame_done (frame_done),
        .locked     (locked),
        .line_len   (line_len),
        .frame_lines(frame_lines)
    );

    int checks = 0;
    int failures = 0;

    int gx, gy, sx, sy;
    int fh = T_VTW;
    int long_y = -1;
    int vs_dly = 0;
    int wr_cnt, fd_cnt, pix_err;
    int fx, fy, lx, ly;
    bit chk_pix;
    int lw [T_VTW];

    // drive one source clock, sample after the edge, advance raster
    task automatic step();
        int cw;
        int px;
        logic [2:0] c;
        cw = (gy == long_y) ? T_HZW + 1 : T_HZW;
        vid.hs = !(gx >= cw - T_HZS);
        vid.vs = !((gy >= fh - T_VTS) || (gy == 0 && gx < vs_dly));
        px = gx - 1;
        c = 3'd0;
        if (px >= T_HZB && px < T_HZB + T_HZV &&
            gy >= T_VTB && gy < T_VTB + T_VTV)
            c = 3'(px - T_HZB) ^ 3'(gy - T_VTB);
        {vid.r, vid.g, vid.b} = c;
        sx = gx;
        sy = gy;
        @(posedge clock);
        #1;
        if (we === 1'b1) begin
            wr_cnt++;
            if (wr_cnt == 1) begin
                fx = int'(x);
                fy = int'(y);
            end
            lx = int'(x);
            ly = int'(y);
            if (chk_pix && data !== (x[2:0] ^ y[2:0])) pix_err++;
            lw[sy]++;
        end
        if (frame_done === 1'b1) fd_cnt++;
        if (gx >= cw - 1) begin
            gx = 0;
            gy = (gy >= fh - 1) ? 0 : gy + 1;
        end else begin
            gx++;
        end
    endtask

    task automatic run_until(input int tx, input int ty);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(sx == tx && sy == ty) && n < 2000);
        if (!(sx == tx && sy == ty)) begin
            failures++;
            $display("FAIL wait_xy got=(%0d,%0d) want=(%0d,%0d)",
                     sx, sy, tx, ty);
        end
    endtask

    task automatic test_reset();
        gx = 0;
        gy = T_VTW - 1;
        vid.hs = 1'b1;
        vid.vs = 1'b0;
        {vid.r, vid.g, vid.b} = 3'd0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({we, x, y, data} !== 23'd0) begin
            failures++;
            $display("FAIL reset_wr got=%0h want=0", {we, x, y, data});
        end
        checks++;
        if ({frame_done, locked} !== 2'b00) begin
            failures++;
            $display("FAIL reset_flags got=%b want=00",
                     {frame_done, locked});
        end
        checks++;
        if ({line_len, frame_lines} !== 23'd0) begin
            failures++;
            $display("FAIL reset_meas got=%0h want=0",
                     {line_len, frame_lines});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock();
        chk_pix = 1'b0;
        run_until(0, 0);
        checks++;
        if ({frame_done, locked, frame_lines} !== {2'b10, 11'd0}) begin
            failures++;
            $display("FAIL lock_b1 fd=%b lk=%b fl=%0d want fd=1 lk=0 fl=0",
                     frame_done, locked, frame_lines);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL lock_b2 locked=%b want=0", locked);
        end
        checks++;
        if (line_len !== 12'd32 || frame_lines !== 11'd13) begin
            failures++;
            $display("FAIL lock_meas ll=%0d fl=%0d want ll=32 fl=13",
                     line_len, frame_lines);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_b3 locked=%b want=1", locked);
        end
        wr_cnt = 0;
        pix_err = 0;
        chk_pix = 1'b1;
        run_until(0, 0);
        checks++;
        if (wr_cnt !== T_HZV * T_VTV) begin
            failures++;
            $display("FAIL frame_writes got=%0d want=%0d",
                     wr_cnt, T_HZV * T_VTV);
        end
        checks++;
        if (fx !== 0 || fy !== 0 || lx !== 15 || ly !== 5) begin
            failures++;
            $display("FAIL frame_ends got=(%0d,%0d)..(%0d,%0d) want=(0,0)..(15,5)",
                     fx, fy, lx, ly);
        end
        checks++;
        if (pix_err !== 0) begin
            failures++;
            $display("FAIL frame_data bad=%0d want=0", pix_err);
        end
    endtask

    task automatic test_boundary_pixels();
        chk_pix = 1'b1;
        foreach (lw[i]) lw[i] = 0;
        for (int i = 0; i < T_HZW * T_VTW; i++) begin
            step();
            if (sy == 4 && (sx == 6 || sx == 23)) begin
                checks++;
                if (we !== 1'b0) begin
                    failures++;
                    $display("FAIL edge_nowr sx=%0d we=%b want=0", sx, we);
                end
            end
            if (sy == 4 && sx == 7) begin
                checks++;
                if ({we, x, y, data} !== {1'b1, 10'd0, 9'd1, 3'd1}) begin
                    failures++;
                    $display("FAIL edge_first got we=%b x=%0d y=%0d d=%0d want 1/0/1/1",
                             we, x, y, data);
                end
            end
            if (sy == 4 && sx == 22) begin
                checks++;
                if ({we, x, y, data} !== {1'b1, 10'd15, 9'd1, 3'd6}) begin
                    failures++;
                    $display("FAIL edge_last got we=%b x=%0d y=%0d d=%0d want 1/15/1/6",
                             we, x, y, data);
                end
            end
            if (sy == 8 && sx == 12) begin
                checks++;
                if ({we, x, y, data} !== {1'b1, 10'd5, 9'd5, 3'd0}) begin
                    failures++;
                    $display("FAIL edge_row5 got we=%b x=%0d y=%0d d=%0d want 1/5/5/0",
                             we, x, y, data);
                end
            end
        end
        checks++;
        if (lw[2] !== 0 || lw[9] !== 0) begin
            failures++;
            $display("FAIL edge_rows_out l2=%0d l9=%0d want 0/0",
                     lw[2], lw[9]);
        end
        checks++;
        if (lw[3] !== 16 || lw[8] !== 16) begin
            failures++;
            $display("FAIL edge_rows_in l3=%0d l8=%0d want 16/16",
                     lw[3], lw[8]);
        end
    endtask

    task automatic test_long_line();
        chk_pix = 1'b0;
        long_y = 5;
        run_until(0, 5);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL long_pre locked=%b want=1", locked);
        end
        run_until(0, 6);
        long_y = -1;
        checks++;
        if (locked !== 1'b0 || line_len !== 12'd33) begin
            failures++;
            $display("FAIL long_hit lk=%b ll=%0d want lk=0 ll=33",
                     locked, line_len);
        end
        wr_cnt = 0;
        run_until(0, 0);
        checks++;
        if (wr_cnt !== 0 || locked !== 1'b0) begin
            failures++;
            $display("FAIL long_stop wr=%0d lk=%b want wr=0 lk=0",
                     wr_cnt, locked);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0 || line_len !== 12'd32) begin
            failures++;
            $display("FAIL long_b1 lk=%b ll=%0d want lk=0 ll=32",
                     locked, line_len);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL long_relock locked=%b want=1", locked);
        end
    endtask

    task automatic test_short_frame();
        fh = 10;
        fd_cnt = 0;
        run_until(0, 0);
        fh = T_VTW;
        checks++;
        if (frame_lines !== 11'd10 || locked !== 1'b0) begin
            failures++;
            $display("FAIL short_meas fl=%0d lk=%b want fl=10 lk=0",
                     frame_lines, locked);
        end
        checks++;
        if (frame_done !== 1'b1 || fd_cnt !== 1) begin
            failures++;
            $display("FAIL short_fd fd=%b n=%0d want fd=1 n=1",
                     frame_done, fd_cnt);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0) begin
            failures++;
            $display("FAIL short_b1 locked=%b want=0", locked);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b1 || frame_lines !== 11'd13) begin
            failures++;
            $display("FAIL short_relock lk=%b fl=%0d want lk=1 fl=13",
                     locked, frame_lines);
        end
    endtask

    task automatic test_vs_delay();
        run_until(0, 6);
        vs_dly = 5;
        fd_cnt = 0;
        run_until(0, 0);
        checks++;
        if (frame_done !== 1'b0) begin
            failures++;
            $display("FAIL vsd_early fd=%b want=0", frame_done);
        end
        run_until(0, 1);
        checks++;
        if (frame_done !== 1'b1 || fd_cnt !== 1 ||
            frame_lines !== 11'd14 || locked !== 1'b0) begin
            failures++;
            $display("FAIL vsd_first fd=%b n=%0d fl=%0d lk=%b want 1/1/14/0",
                     frame_done, fd_cnt, frame_lines, locked);
        end
        run_until(0, 1);
        checks++;
        if (frame_lines !== 11'd13 || locked !== 1'b0) begin
            failures++;
            $display("FAIL vsd_b1 fl=%0d lk=%b want fl=13 lk=0",
                     frame_lines, locked);
        end
        run_until(0, 1);
        checks++;
        if (frame_lines !== 11'd13 || locked !== 1'b1) begin
            failures++;
            $display("FAIL vsd_lock fl=%0d lk=%b want fl=13 lk=1",
                     frame_lines, locked);
        end
    endtask

    task automatic test_mid_reset();
        vs_dly = 0;
        run_until(10, 5);
        checks++;
        if (locked !== 1'b1 || we !== 1'b1) begin
            failures++;
            $display("FAIL mrst_pre lk=%b we=%b want 1/1", locked, we);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({we, x, y, data, frame_done, locked} !== 25'd0) begin
            failures++;
            $display("FAIL mrst_async got=%0h want=0",
                     {we, x, y, data, frame_done, locked});
        end
        checks++;
        if ({line_len, frame_lines} !== 23'd0) begin
            failures++;
            $display("FAIL mrst_meas got=%0h want=0",
                     {line_len, frame_lines});
        end
        repeat (3) step();
        reset_n = 1'b1;
        run_until(0, 0);
        checks++;
        if ({frame_done, locked, frame_lines} !== {2'b10, 11'd0}) begin
            failures++;
            $display("FAIL mrst_b0 fd=%b lk=%b fl=%0d want 1/0/0",
                     frame_done, locked, frame_lines);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b0 || frame_lines !== 11'd13) begin
            failures++;
            $display("FAIL mrst_b1 lk=%b fl=%0d want lk=0 fl=13",
                     locked, frame_lines);
        end
        run_until(0, 0);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL mrst_relock locked=%b want=1", locked);
        end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_boundary_pixels();
        test_long_line();
        test_short_frame();
        test_vs_delay();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/video_capture.md
Name: video_capture

Overview:
- VGA-style video receiver: the sink end of the 640x400 sync/RGB stream our video generator produces.
- Recovers pixel coordinates from the hs/vs sync pulses and measures line and frame lengths.
- Declares lock after consecutive good frames and emits one framebuffer write per visible pixel.
- Same pixel clock as the source; sits between the video output and a capture framebuffer (loopback and self-test).

Parameters:
- HZV, 640, visible pixels per line
- HZB, 48, back porch (clocks from hs rise to first visible pixel)
- HZW, 800, total clocks per line
- VTV, 400, visible lines
- VTB, 35, back-porch lines (vs rise to first visible line)
- VTW, 449, total lines per frame
- PIX_DELAY, 1, clocks by which r/g/b lag hs/vs at the input; must be < HZB
- LOCK_FRAMES, 2, consecutive good frames required for lock

Ports:
- clock  in  1  pixel clock
- reset_n  in  1  asynchronous active-low reset
- hs  in  1  horizontal sync, active low; rising edge = source X=0
- vs  in  1  vertical sync, active low; rising edge = source Y=0
- r, g, b  in  1 each  pixel colour
- we  out  1  pixel write strobe
- x  out  10  visible pixel column 0..HZV-1
- y  out  9  visible pixel row 0..VTV-1
- data  out  3  {r,g,b} of the written pixel
- frame_done  out  1  one-cycle pulse at each consumed vs edge
- locked  out  1  timing lock
- line_len  out  12  last measured line length in clocks
- frame_lines  out  11  last measured frame length in lines

Behaviour:
- Reset (async, reset_n=0): all outputs 0; hs_d/vs_d=1; hc, vc, good counter, flags cleared.
- Edge detection: hs_d, vs_d hold the previous-cycle hs and vs; hrise = hs & ~hs_d; vrise = vs & ~vs_d.
- Horizontal counter:
  - hc is 12 bits; on hrise hc<=1, else hc<=hc+1, saturating at 4095.
  - Current source X = hrise ? 0 : hc.
- Line measurement on hrise:
  - line_len<=hc, only if have_line is set.
  - have_line is set on the first hrise after reset.
  - If have_line and hc!=HZW: line_bad<=1, locked<=0, good<=0 in that cycle.
- Vertical:
  - vrise sets vs_pend.
  - On hrise with (vs_pend | vrise): this is the frame boundary. frame_lines<=vc+1 if have_frame; vc<=0; vs_pend<=0; frame_done pulses next cycle.
  - Otherwise on hrise: vc<=vc+1, 11 bits, saturating.
  - vrise coincident with hrise is handled in the same cycle.
  - vs rising off-edge is deferred to the next hrise.
- Frame judgement at each boundary:
  - Frame is good if have_frame, vc+1==VTW and line_bad==0.
  - Good frame: good<=good+1, saturating at LOCK_FRAMES; locked<=1 when good+1>=LOCK_FRAMES.
  - Bad frame: good<=0, locked<=0.
  - line_bad<=0 at every boundary.
  - have_frame is set at the first boundary after reset; that boundary is never judged.
- Pixel path (one registered stage):
  - Pixel coordinate xp = X-PIX_DELAY; yp = vc.
  - When locked and HZB<=xp<HZB+HZV and VTB<=yp<VTB+VTV: next cycle we=1, x=xp-HZB, y=yp-VTB, data={r,g,b}.
  - Otherwise we=0; x/y/data hold their previous values.
- Latency: r/g/b sampled at cycle t appear on data at t+1.
- Lock behaviour:
  - Lock loss takes effect in the same cycle as the detecting hrise or boundary.
  - Writes stop immediately when lock is lost.
  - Re-lock requires LOCK_FRAMES fresh good frames.
- Mid-operation reset: everything restarts; the first partial frame is discarded because have_frame is clear.

Decomposition:
- Shared package video_pkg holds:
  - the timing constants (HZV/HZF/HZS/HZB/HZW, VTV/VTF/VTS/VTB/VTW) used by both generator and capture;
  - a typedef for the 3-bit rgb pixel.
- One natural sub-module, video_sync_edge: registers one sync input and produces its rise pulse. It is instantiated twice, for hs and vs.

Test Plan:
1. Reset, then 3 ideal frames (rgb=X[2:0]^Y[2:0] from a generator model):
   - locked rises at the 3rd boundary (2nd judged frame);
   - line_len=800, frame_lines=449;
   - frame 4 yields exactly 256000 writes, first x=0,y=0, last x=639,y=399, data matching the pattern.
2. Boundary pixels:
   - no write for source X=HZB-1 or X=HZB+HZV;
   - no write for line VTB-1 or VTB+VTV;
   - x=639 written at source X=687.
3. One line of 801 clocks while locked -> locked=0 on that hrise, line_len=801; relock two frames later.
4. Frame of 410 lines -> frame_lines=410, locked=0 at that boundary, frame_done still pulses.
5. vs rise delayed 5 clocks after hrise -> vc resets at the following hrise, frame_lines=449, lock still achieved.
6. reset_n low for 3 clocks mid-frame -> all outputs 0 asynchronously; first partial frame ignored; locked after 2 further full frames.
